// File: rtl/pe_pkg.sv
// Shared definitions for the pe_unit operand sequencer: FSM states and slot/round constants.
package pe_pkg;

  localparam int PE_SLOTS        = 8;
  localparam int PE_ROUND_CYCLES = 2;
  localparam int PE_SLOT_W       = $clog2(PE_SLOTS);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    ROUND0,
    ROUND1
  } pe_feeder_state_e;

endpackage

// File: rtl/pe_tag_fifo.sv
// Small synchronous FIFO holding the slot tag of each round in flight through pe_unit.
module pe_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; only entries between the reset pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Operand sequencer for pe_unit: feeds one dot-product vector, then a two-cycle rounding phase.
// Optional dirty-slot detection is enabled by defining PE_FEEDER_DIRTY_CHECK_EN.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int INT_BITS  = 7,
  parameter int FRAC_BITS = 9,
  parameter int LEN_W     = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [PE_SLOT_W-1:0]          cmd_slot,
  input  logic [LEN_W-1:0]              cmd_len,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [INT_BITS+FRAC_BITS-1:0] op_a,
  input  logic [INT_BITS+FRAC_BITS-1:0] op_b,
  output logic [INT_BITS+FRAC_BITS-1:0] pe_data_in_1,
  output logic [INT_BITS+FRAC_BITS-1:0] pe_data_in_2,
  output logic [3:0]                    pe_add_number,
  output logic                          pe_keep,
  output logic                          pe_rounder_en,
  input  logic                          pe_rounder_valid,
  output logic [PE_SLOT_W-1:0]          res_slot,
  output logic                          res_slot_valid,
  output logic                          busy
`ifdef PE_FEEDER_DIRTY_CHECK_EN
  ,
  output logic                          err_dirty
`endif
);

  localparam int W = INT_BITS + FRAC_BITS;

  pe_feeder_state_e     state;
  pe_feeder_state_e     state_next;
  logic [PE_SLOT_W-1:0] slot_q;
  logic [LEN_W-1:0]     remaining;
  logic                 cmd_fire;
  logic                 op_fire;
  logic                 tag_push;
  logic                 tag_empty;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign op_fire  = op_valid && op_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    cmd_ready    = 1'b0;
    op_ready     = 1'b0;
    pe_keep      = 1'b1;
    pe_rounder_en = 1'b0;
    pe_data_in_1 = '0;
    pe_data_in_2 = '0;
    tag_push     = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) state_next = (cmd_len != '0) ? FEED : ROUND0;
      end
      FEED: begin
        op_ready = !rst;
        pe_keep  = !op_valid;
        if (op_valid) begin
          pe_data_in_1 = op_a;
          pe_data_in_2 = op_b;
          if (remaining == LEN_W'(1)) state_next = ROUND0;
        end
      end
      ROUND0: begin
        pe_keep       = 1'b0;
        pe_rounder_en = 1'b1;
        tag_push      = 1'b1;
        state_next    = ROUND1;
      end
      // Guard cycle: pe_unit blocks writes two cycles after rounder_en, so only a zero pair is safe.
      ROUND1: begin
        pe_keep    = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot_q    <= '0;
      remaining <= '0;
    end else begin
      state <= state_next;
      if (cmd_fire) begin
        slot_q    <= cmd_slot;
        remaining <= cmd_len;
      end else if (op_fire) begin
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  assign pe_add_number = {1'b0, slot_q};

  pe_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (PE_SLOT_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (slot_q),
    .pop   (pe_rounder_valid),
    .empty (tag_empty),
    .head  (res_slot)
  );

  assign res_slot_valid = pe_rounder_valid && !tag_empty;
  assign busy           = (state != IDLE) || !tag_empty;

`ifdef PE_FEEDER_DIRTY_CHECK_EN
  // A slot becomes dirty once rounded; re-targeting it without reset is flagged but still run.
  logic [PE_SLOTS-1:0] dirty;

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty     <= '0;
      err_dirty <= 1'b0;
    end else begin
      if (tag_push) dirty[slot_q] <= 1'b1;
      if (cmd_fire && dirty[cmd_slot]) err_dirty <= 1'b1;
    end
  end
`endif

endmodule
